// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the serial instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} loader_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   localparam int unsigned DEFAULT_DEPTH = 32;
   localparam int unsigned WORD_W        = 16;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, bit timer and RX FSM.
// Held in R_IDLE while en is low, so frames outside a load are dropped.
module uart_rx
   import imem_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_t     state;
   logic [1:0]    sync;
   logic          rx_s;
   logic          rx_q;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   assign rx_s    = sync[1];
   assign rx_byte = shift;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync       <= '1;
         rx_q       <= 1'b1;
         state      <= R_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync       <= {sync[0], rx};
         rx_q       <= rx_s;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (!en) begin
            state <= R_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               R_IDLE: begin
                  if (rx_q && !rx_s) begin
                     state <= R_START;
                     cnt   <= '0;
                  end
               end
               R_START: begin
                  if (cnt == HALF_LAST) begin
                     cnt     <= '0;
                     bit_idx <= '0;
                     state   <= rx_s ? R_IDLE : R_DATA;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               R_DATA: begin
                  if (cnt == BIT_LAST) begin
                     cnt     <= '0;
                     shift   <= {rx_s, shift[7:1]};
                     bit_idx <= bit_idx + 1'b1;
                     if (bit_idx == 3'd7) state <= R_STOP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               R_STOP: begin
                  if (cnt == BIT_LAST) begin
                     cnt        <= '0;
                     byte_valid <= rx_s;
                     frame_err  <= !rx_s;
                     state      <= R_IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= R_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Serial instruction-memory loader: UART bytes packed into 16-bit writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned DEPTH    = DEFAULT_DEPTH,
   localparam int unsigned AW      = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   input  logic              start,
   output logic              we,
   output logic [AW-1:0]     waddr,
   output logic [WORD_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

   loader_state_t state;
   logic [AW-1:0] word_cnt;
   logic          phase;
   logic [7:0]    hi_byte;
   logic [7:0]    rx_byte;
   logic          byte_valid;
   logic          frame_err;
   logic          rx_en;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]    sum;
`endif

   assign rx_en = (state == LOAD) || (state == CHECK);

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .en         (rx_en),
      .rx         (rx),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         word_cnt <= '0;
         phase    <= 1'b0;
         hi_byte  <= '0;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum      <= '0;
`endif
      end else begin
         we <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  word_cnt <= '0;
                  phase    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum      <= '0;
`endif
               end
            end
            LOAD: begin
               if (frame_err) begin
                  state <= ERROR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               // Completion keys off the final we pulse so done lands one cycle after it
               end else if (we && waddr == AW'(DEPTH - 1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state <= CHECK;
`else
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`endif
               end else if (byte_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum <= sum + rx_byte;
`endif
                  if (!phase) begin
                     hi_byte <= rx_byte;
                     phase   <= 1'b1;
                  end else begin
                     we       <= 1'b1;
                     waddr    <= word_cnt;
                     wdata    <= {hi_byte, rx_byte};
                     word_cnt <= word_cnt + 1'b1;
                     phase    <= 1'b0;
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
               if (frame_err) begin
                  state <= ERROR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else if (byte_valid) begin
                  busy <= 1'b0;
                  if ((sum + rx_byte) == 8'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ERROR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (CLKS_PER_BIT = 10).
// Checksum scenarios run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

   localparam int unsigned CPB = 10;
   localparam int unsigned AW  = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx = 1'b1;
   logic          start = 1'b0;
   logic          we;
   logic [AW-1:0] waddr;
   logic [15:0]   wdata;
   logic          busy;
   logic          done;
   logic          err;

   int checks = 0;
   int errors = 0;

   int   wr_addr[$];
   int   wr_data[$];
   int   cyc = 0;
   int   last_we_cyc = -100;
   int   done_cyc = -1;
   int   busy_fall_cyc = -1;
   logic done_q = 1'b0;
   logic busy_q = 1'b0;

   always #5 clk = ~clk;

   imem_loader #(.CLK_FREQ(1000), .BAUD(100), .DEPTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .start (start),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   // Write log and edge timestamps, sampled away from the active edge
   always @(negedge clk) begin
      cyc++;
      if (we === 1'b1) begin
         wr_addr.push_back(int'(waddr));
         wr_data.push_back(int'(wdata));
         last_we_cyc = cyc;
      end
      if (done === 1'b1 && done_q !== 1'b1) done_cyc = cyc;
      if (busy === 1'b0 && busy_q === 1'b1) busy_fall_cyc = cyc;
      done_q = done;
      busy_q = busy;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop_bit;
      tick(CPB);
      rx = 1'b1;
      if (!stop_bit) tick(CPB);
   endtask

   task automatic send_seq(input int first, input int n);
      for (int i = 0; i < n; i++) send_byte(8'(first + i), 1'b1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(2);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(3);
   endtask

   task automatic check_outputs_idle(input string tag);
      check({tag, "_we"},    32'(we),    32'd0);
      check({tag, "_waddr"}, 32'(waddr), 32'd0);
      check({tag, "_wdata"}, 32'(wdata), 32'd0);
      check({tag, "_busy"},  32'(busy),  32'd0);
      check({tag, "_done"},  32'(done),  32'd0);
      check({tag, "_err"},   32'(err),   32'd0);
   endtask

   // Expect n writes since log index base: addresses 0.. and data {2i, 2i+1}
   task automatic check_ramp(input string tag, input int base, input int n);
      check({tag, "_nwr"}, 32'(wr_addr.size() - base), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (base + i < wr_addr.size()) begin
            check({tag, "_waddr"}, 32'(wr_addr[base + i]), 32'(i));
            check({tag, "_wdata"}, 32'(wr_data[base + i]), {16'd0, 8'(2 * i), 8'(2 * i + 1)});
         end
      end
   endtask

   // Completion of a 0x00..0x3F load; with checksum the byte 0x20 closes it (sum 0x7E0)
   task automatic finish_ramp_load(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
      tick(20);
      check({tag, "_chk_busy"}, 32'(busy), 32'd1);
      check({tag, "_chk_done"}, 32'(done), 32'd0);
      send_byte(8'h20, 1'b1);
`endif
      tick(20);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_err"},  32'(err),  32'd0);
      check({tag, "_busy_done_same"}, 32'(busy_fall_cyc - done_cyc), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      check({tag, "_done_lat"}, 32'(done_cyc - last_we_cyc), 32'd1);
`endif
   endtask

   initial begin
      int base;

      // Reset values
      do_reset();
      check_outputs_idle("rst");

      // Full sequential load
      base = wr_addr.size();
      pulse_start();
      check("load_busy", 32'(busy), 32'd1);
      send_seq(0, 64);
      finish_ramp_load("full");
      check_ramp("full", base, 32);

      // Bytes after DONE are discarded
      base = wr_addr.size();
      send_seq(8'h70, 2);
      tick(20);
      check("done_discard_nwr", 32'(wr_addr.size() - base), 32'd0);

      // Reset mid-byte during word 5, then a clean load restarts at address 0
      do_reset();
      base = wr_addr.size();
      pulse_start();
      send_seq(0, 10);
      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      tick(15);
      check("pre_rst_nwr", 32'(wr_addr.size() - base), 32'd5);
      reset = 1'b1;
      #2;
      check_outputs_idle("async_rst");
      tick(2);
      reset = 1'b0;
      tick(20);
      base = wr_addr.size();
      send_seq(8'h40, 2);
      tick(20);
      check("idle_discard_nwr", 32'(wr_addr.size() - base), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      pulse_start();
      send_seq(0, 64);
      finish_ramp_load("reload");
      check_ramp("reload", base, 32);

      // Framing error on the third byte
      do_reset();
      base = wr_addr.size();
      pulse_start();
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b0);
      tick(5);
      check("ferr_err",  32'(err),  32'd1);
      check("ferr_busy", 32'(busy), 32'd0);
      check("ferr_done", 32'(done), 32'd0);
      send_seq(8'h80, 4);
      tick(20);
      check("ferr_nwr", 32'(wr_addr.size() - base), 32'd1);
      if (wr_addr.size() > base) check("ferr_wdata", 32'(wr_data[base]), 32'h1234);
      check("ferr_err_hold", 32'(err), 32'd1);

      // Short low glitch is rejected, following frame is received
      do_reset();
      base = wr_addr.size();
      pulse_start();
      tick(10);
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(40);
      check("glitch_nwr",  32'(wr_addr.size() - base), 32'd0);
      check("glitch_err",  32'(err),  32'd0);
      check("glitch_busy", 32'(busy), 32'd1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h5A, 1'b1);
      tick(5);
      check("glitch_nwr2", 32'(wr_addr.size() - base), 32'd1);
      if (wr_addr.size() > base) begin
         check("glitch_waddr", 32'(wr_addr[base]), 32'd0);
         check("glitch_wdata", 32'(wr_data[base]), 32'hA55A);
      end

      // start during LOAD at word 10 is ignored
      do_reset();
      base = wr_addr.size();
      pulse_start();
      send_seq(0, 20);
      pulse_start();
      check("restart_busy", 32'(busy), 32'd1);
      send_seq(20, 44);
      finish_ramp_load("ign_start");
      check_ramp("ign_start", base, 32);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // 64 x 0x01 sums to 0x40; 0xC0 closes to zero, 0xC1 does not
      do_reset();
      base = wr_addr.size();
      pulse_start();
      for (int i = 0; i < 64; i++) send_byte(8'h01, 1'b1);
      send_byte(8'hC0, 1'b1);
      tick(20);
      check("cs_ok_done", 32'(done), 32'd1);
      check("cs_ok_err",  32'(err),  32'd0);
      check("cs_ok_nwr",  32'(wr_addr.size() - base), 32'd32);
      if (wr_addr.size() > base + 31) check("cs_ok_last", 32'(wr_data[base + 31]), 32'h0101);

      base = wr_addr.size();
      pulse_start();
      check("cs_bad_start_done", 32'(done), 32'd0);
      for (int i = 0; i < 64; i++) send_byte(8'h01, 1'b1);
      send_byte(8'hC1, 1'b1);
      tick(20);
      check("cs_bad_err",  32'(err),  32'd1);
      check("cs_bad_done", 32'(done), 32'd0);
      check("cs_bad_busy", 32'(busy), 32'd0);
      check("cs_bad_nwr",  32'(wr_addr.size() - base), 32'd32);
      if (wr_addr.size() > base + 31) check("cs_bad_addr", 32'(wr_addr[base + 31]), 32'd31);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
